instr_aligner: RTL and testbench
================================

# instr_aligner

Fetch-side instruction aligner for the RV32IC core. It accepts word-aligned 32-bit fetch words and emits one instruction per handshake: either a 16-bit compressed instruction (zero-extended) or a full 32-bit instruction. It handles 32-bit instructions that straddle two fetch words. It sits between instruction memory and the decompressor/decode stage, and performs the splitting that is the inverse of the word assembly done on the fetch path.

## Interface
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- No parameters. Widths are fixed at 32-bit XLEN and 16-bit parcels.
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous active-high reset
- `flush` in 1: redirect; discards all buffered data
- `flush_pc` in 32: redirect target; bit 1 selects the start parcel, bit 0 is ignored
- `w_valid` in 1: fetch word available
- `w_ready` out 1: aligner accepts the word this cycle
- `w_data` in 32: fetch word, little-endian parcels
- `w_pc` in 32: word-aligned address of `w_data`
- `i_valid` out 1: instruction available
- `i_ready` in 1: decode accepts the instruction
- `i_instr` out 32: instruction; compressed instructions are `{16'h0, parcel}`
- `i_pc` out 32: address of the instruction's first parcel
- `i_is_c` out 1: instruction is compressed

## Operation
- **Length rule:** a parcel with bits [1:0]==2'b11 starts a 32-bit instruction. Any other value is a 16-bit instruction.
- **Registers:** `buf_word[31:0]`, `buf_pc[31:0]`, `pend[15:0]`, `pend_pc[31:0]`, `start_hi`, and a 5-state FSM.
- **IDLE** (buffer empty)
  - `w_ready`=1.
  - On accept: load `buf_word`/`buf_pc`.
  - Next state is HI if `start_hi`=1, otherwise LO. `start_hi` then clears.
- **LO** (low parcel current)
  - If 32-bit: present `buf_word` at `buf_pc`. Handshake → IDLE.
  - If 16-bit: present `{16'h0, buf_word[15:0]}`, `i_is_c`=1. Handshake → HI.
- **HI** (high parcel current, `i_pc` = `buf_pc`+2)
  - If 16-bit: present it. Handshake → IDLE.
  - If 32-bit: no output. Next cycle → SPLIT, with `pend`=`buf_word[31:16]` and `pend_pc`=`buf_pc`+2.
- **SPLIT**
  - `w_ready`=1.
  - On accept: load the new word → JOIN.
- **JOIN**
  - Present `{buf_word[15:0], pend}` at `pend_pc`, `i_is_c`=0.
  - Handshake → HI, which continues with the new word's high parcel.
- **Ready rule:** `w_ready`=0 in LO, HI and JOIN. `w_ready` is also 0 whenever `flush` or `rst` is high.
- **Output qualification:** when `i_valid`=0, `i_instr`, `i_pc` and `i_is_c` are driven to 0.
- **Flush** has priority over every handshake in the same cycle:
  - FSM → IDLE; the `pend` contents are discarded.
  - `start_hi` ← `flush_pc[1]`.
  - A word offered in the flush cycle is not accepted, and an instruction presented in that cycle is not consumed.
- **Address arithmetic:** PC additions are modulo 2^32. A split at 0xFFFFFFFE joins with the word at 0x00000000.
- **Upstream contract:** after a split, the next accepted word belongs to `pend_pc`+2. The aligner does not check this.

## Timing
- **Reset values:**
  - FSM=IDLE, `start_hi`=0.
  - `i_valid`=0, `i_instr`=0, `i_pc`=0, `i_is_c`=0.
  - `w_ready`=0 during `rst`, 1 in the first cycle after it.
- **Latency:** a word accepted in cycle N gives `i_valid`=1 in cycle N+1. A straddling instruction costs one extra bubble cycle (HI→SPLIT) before the next word is accepted.
- **Throughput:** at most one instruction per cycle. A word is accepted only when the buffer is empty, so there is no full/overflow state.
- **Output stability:** while `i_valid`=1 and `i_ready`=0, all `i_*` outputs are held stable until handshake, flush or reset.
- **Reset mid-operation:** clears the FSM and `pend`. The next cycle shows `i_valid`=0.

## Structure
- **Shared package `rv_defs_pkg`:**
  - FSM state encoding (IDLE, LO, HI, SPLIT, JOIN)
  - `PARCEL_W`=16
  - `LEN32_CODE`=2'b11
- **Parcel selection:** reuses the team's existing 2:1 MUX with n=16.
- No other sub-module is needed.

## Test plan
1. **Single 32-bit word:** word 0x00000013 at 0x000 → one instruction 0x00000013, pc 0x000, `i_is_c`=0, then IDLE.
2. **Two compressed parcels:** word 0x45014501 at 0x100 → 0x00004501 at pc 0x100 (c=1), then 0x00004501 at pc 0x102 (c=1).
3. **Straddling instruction:** words 0x00134501 at 0x200 and 0x45010000 at 0x204 → 0x00004501 at 0x200, then 0x00000013 at 0x202 (one bubble before JOIN), then 0x00004501 at 0x206.
4. **Backpressure:** `i_ready`=0 for 5 cycles with `i_valid`=1 → `i_instr`/`i_pc` unchanged and `w_ready`=0 throughout. Release → the next instruction follows in order.
5. **Flush during SPLIT:** `flush`, `flush_pc`=0x302, then word 0x45010013 at 0x300 → only 0x00004501 at pc 0x302 is output. The discarded `pend` never appears.
6. **Reset mid-operation:** `rst` pulsed while `i_valid`=1 in JOIN → next cycle `i_valid`=0, `i_instr`=0, `w_ready`=1, FSM=IDLE.

Source files
------------

// File: rtl/rv_defs_pkg.sv
// Shared RV32IC fetch definitions: parcel geometry, length decode and aligner FSM encoding.
package rv_defs_pkg;

    localparam int unsigned PARCEL_W   = 16;
    localparam logic [1:0]  LEN32_CODE = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StSplit,
        StJoin
    } align_state_e;

    function automatic logic is_len32(input logic [PARCEL_W-1:0] parcel);
        return parcel[1:0] == LEN32_CODE;
    endfunction

endpackage

// File: rtl/instr_aligner_mux2.sv
// Generic 2:1 multiplexer, used by the aligner to pick the current 16-bit parcel.
module instr_aligner_mux2 #(
    parameter int unsigned N = 16
) (
    input  logic         sel_i,
    input  logic [N-1:0] in0_i,
    input  logic [N-1:0] in1_i,
    output logic [N-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/instr_aligner.sv
// Splits word-aligned fetch words into 16/32-bit RV32IC instructions, including
// 32-bit instructions straddling two fetch words.
module instr_aligner
    import rv_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [31:0] w_data,
    input  logic [31:0] w_pc,
    output logic        i_valid,
    input  logic        i_ready,
    output logic [31:0] i_instr,
    output logic [31:0] i_pc,
    output logic        i_is_c
);

    align_state_e          state_q, state_d;
    logic [31:0]           buf_word_q, buf_word_d;
    logic [31:0]           buf_pc_q, buf_pc_d;
    logic [PARCEL_W-1:0]   pend_q, pend_d;
    logic [31:0]           pend_pc_q, pend_pc_d;
    logic                  start_hi_q, start_hi_d;

    logic [PARCEL_W-1:0]   parcel;
    logic                  parcel_len32;
    logic [31:0]           buf_pc_hi;
    logic                  w_accept;
    logic                  i_accept;

    instr_aligner_mux2 #(
        .N(PARCEL_W)
    ) u_parcel_mux (
        .sel_i(state_q == StHi),
        .in0_i(buf_word_q[15:0]),
        .in1_i(buf_word_q[31:16]),
        .out_o(parcel)
    );

    assign parcel_len32 = is_len32(parcel);
    assign buf_pc_hi    = buf_pc_q + 32'd2;

    always_comb begin
        w_ready = 1'b0;
        i_valid = 1'b0;
        i_instr = '0;
        i_pc    = '0;
        i_is_c  = 1'b0;
        unique case (state_q)
            StIdle, StSplit: w_ready = 1'b1;
            StLo: begin
                i_valid = 1'b1;
                i_pc    = buf_pc_q;
                i_is_c  = !parcel_len32;
                i_instr = parcel_len32 ? buf_word_q : {16'h0, parcel};
            end
            StHi: begin
                // A 32-bit start in the high parcel produces nothing until its tail arrives.
                if (!parcel_len32) begin
                    i_valid = 1'b1;
                    i_pc    = buf_pc_hi;
                    i_is_c  = 1'b1;
                    i_instr = {16'h0, parcel};
                end
            end
            StJoin: begin
                i_valid = 1'b1;
                i_pc    = pend_pc_q;
                i_instr = {buf_word_q[15:0], pend_q};
            end
            default: ;
        endcase
        if (flush || rst) begin
            w_ready = 1'b0;
        end
    end

    assign w_accept = w_valid && w_ready;
    assign i_accept = i_valid && i_ready;

    always_comb begin
        state_d    = state_q;
        buf_word_d = buf_word_q;
        buf_pc_d   = buf_pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        start_hi_d = start_hi_q;
        if (w_accept) begin
            buf_word_d = w_data;
            buf_pc_d   = w_pc;
        end
        unique case (state_q)
            StIdle: begin
                if (w_accept) begin
                    state_d    = start_hi_q ? StHi : StLo;
                    start_hi_d = 1'b0;
                end
            end
            StLo: begin
                if (i_accept) begin
                    state_d = parcel_len32 ? StIdle : StHi;
                end
            end
            StHi: begin
                if (parcel_len32) begin
                    pend_d    = parcel;
                    pend_pc_d = buf_pc_hi;
                    state_d   = StSplit;
                end else if (i_accept) begin
                    state_d = StIdle;
                end
            end
            StSplit: begin
                if (w_accept) begin
                    state_d = StJoin;
                end
            end
            StJoin: begin
                if (i_accept) begin
                    state_d = StHi;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d    = StIdle;
            pend_d     = '0;
            start_hi_d = flush_pc[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            buf_word_q <= '0;
            buf_pc_q   <= '0;
            pend_q     <= '0;
            pend_pc_q  <= '0;
            start_hi_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_word_q <= buf_word_d;
            buf_pc_q   <= buf_pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            start_hi_q <= start_hi_d;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Randomised bench for instr_aligner: a parcel-stream reference model predicts the
// instruction sequence of each fetch segment started by a flush.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_is_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] seg_w[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_pc[$];
    logic        exp_c[$];

    always #5 clk = ~clk;

    instr_aligner dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .flush_pc(flush_pc),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .w_pc    (w_pc),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_instr (i_instr),
        .i_pc    (i_pc),
        .i_is_c  (i_is_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] parcel_at(input int j);
        logic [31:0] w;
        w = seg_w[j / 2];
        return (j % 2 == 1) ? w[31:16] : w[15:0];
    endfunction

    // Walk the parcel stream from the start offset; a trailing half instruction yields nothing.
    task automatic build_exp(input logic [31:0] start);
        logic [31:0] base;
        logic [15:0] p0;
        logic [15:0] p1;
        int          total;
        int          idx;
        base  = {start[31:2], 2'b00};
        total = 2 * seg_w.size();
        idx   = start[1] ? 1 : 0;
        exp_instr.delete();
        exp_pc.delete();
        exp_c.delete();
        while (idx < total) begin
            p0 = parcel_at(idx);
            if (p0[1:0] == 2'b11) begin
                if (idx + 1 >= total) break;
                p1 = parcel_at(idx + 1);
                exp_instr.push_back({p1, p0});
                exp_c.push_back(1'b0);
                exp_pc.push_back(base + 32'(2 * idx));
                idx += 2;
            end else begin
                exp_instr.push_back({16'h0, p0});
                exp_c.push_back(1'b1);
                exp_pc.push_back(base + 32'(2 * idx));
                idx += 1;
            end
        end
    endtask

    task automatic do_flush(input logic [31:0] target);
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = target;
        w_valid  = 1'b1;
        w_data   = $urandom;
        w_pc     = 32'h0;
        i_ready  = 1'b1;
        #1;
        check_eq("flush_w_ready", 32'(w_ready), 32'd0);
        @(negedge clk);
        flush   = 1'b0;
        w_valid = 1'b0;
        i_ready = 1'b0;
    endtask

    // Flush to start, stream seg_w from its word-aligned base, compare every handshake.
    task automatic run_seg(input logic [31:0] start);
        logic [31:0] base;
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;
        logic        prev_hold;
        int          widx;
        int          cyc;
        int          idle;
        base      = {start[31:2], 2'b00};
        prev_hold = 1'b0;
        prev_instr = '0;
        prev_pc   = '0;
        widx      = 0;
        cyc       = 0;
        idle      = 0;
        build_exp(start);
        do_flush(start);
        while (idle < 4) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (prev_hold) begin
                check_eq("hold_valid", 32'(i_valid), 32'd1);
                check_eq("hold_instr", i_instr, prev_instr);
                check_eq("hold_pc", i_pc, prev_pc);
            end
            if (!i_valid) begin
                check_eq("qual_instr", i_instr, 32'd0);
                check_eq("qual_pc", i_pc, 32'd0);
            end else begin
                check_eq("busy_w_ready", 32'(w_ready), 32'd0);
            end
            i_ready = ((cyc % 16) >= 5) && ($urandom_range(0, 3) != 0);
            w_valid = (widx < seg_w.size()) && ($urandom_range(0, 3) != 0);
            w_data  = (widx < seg_w.size()) ? seg_w[widx] : $urandom;
            w_pc    = base + 32'(4 * widx);
            #1;
            if (i_valid && i_ready) begin
                if (exp_instr.size() == 0) begin
                    check_eq("extra_instr", i_instr, 32'd0);
                    check_eq("extra_valid", 32'(i_valid), 32'd0);
                end else begin
                    check_eq("instr", i_instr, exp_instr.pop_front());
                    check_eq("pc", i_pc, exp_pc.pop_front());
                    check_eq("is_c", 32'(i_is_c), 32'(exp_c.pop_front()));
                end
            end
            if (w_valid && w_ready) widx++;
            prev_hold  = i_valid && !i_ready;
            prev_instr = i_instr;
            prev_pc    = i_pc;
            if (widx == seg_w.size() && exp_instr.size() == 0) begin
                idle++;
                if (idle > 1) check_eq("drained_valid", 32'(i_valid), 32'd0);
            end
            if (cyc > 400) begin
                check_eq("timeout_left", 32'(exp_instr.size()), 32'd0);
                idle = 4;
            end
        end
        w_valid = 1'b0;
        i_ready = 1'b0;
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] p;
        p = 16'($urandom);
        if ($urandom_range(0, 1) == 1) p[1:0] = 2'b11;
        else if (p[1:0] == 2'b11) p[1:0] = 2'b01;
        return p;
    endfunction

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        flush_pc = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        w_pc     = '0;
        i_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_w_ready", 32'(w_ready), 32'd0);
        check_eq("rst_i_valid", 32'(i_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_w_ready", 32'(w_ready), 32'd1);
        check_eq("post_rst_instr", i_instr, 32'd0);
        check_eq("post_rst_pc", i_pc, 32'd0);
        check_eq("post_rst_is_c", 32'(i_is_c), 32'd0);

        seg_w = '{32'h0000_0013};
        run_seg(32'h0000_0000);
        seg_w = '{32'h4501_4501};
        run_seg(32'h0000_0100);
        seg_w = '{32'h0013_4501, 32'h4501_0000};
        run_seg(32'h0000_0200);
        // Leave the aligner in SPLIT with a pending half, then redirect past it.
        seg_w = '{32'h0013_4501};
        run_seg(32'h0000_02f0);
        seg_w = '{32'h4501_0013};
        run_seg(32'h0000_0302);
        // Straddle across the top of the address space.
        seg_w = '{32'h0013_4501, 32'h4501_0000};
        run_seg(32'hffff_fffc);

        for (int s = 0; s < 30; s++) begin
            logic [31:0] start;
            int          n;
            n = $urandom_range(1, 6);
            seg_w.delete();
            for (int k = 0; k < n; k++) seg_w.push_back({rand_parcel(), rand_parcel()});
            start = (s % 5 == 0) ? 32'hffff_fff0 : $urandom;
            start[0] = 1'b0;
            run_seg(start);
        end

        // Reset while a joined instruction is being presented.
        do_flush(32'h0000_0200);
        w_valid = 1'b1;
        w_data  = 32'h0013_4501;
        w_pc    = 32'h0000_0200;
        i_ready = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        w_valid = 1'b1;
        w_data  = 32'h4501_0000;
        w_pc    = 32'h0000_0204;
        @(negedge clk);
        w_valid = 1'b0;
        check_eq("join_valid", 32'(i_valid), 32'd1);
        check_eq("join_pc", i_pc, 32'h0000_0202);
        check_eq("join_instr", i_instr, 32'h0000_0013);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(i_valid), 32'd0);
        check_eq("mid_rst_instr", i_instr, 32'd0);
        check_eq("mid_rst_w_ready", 32'(w_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
